// File: rtl/obq_ring_if.sv
// rtl/obq_ring_if.sv - fetch/execute/retire request and status bundle for obq_ring
interface obq_ring_if #(
    parameter int DEPTH = 8,
    parameter int BH_W  = 8,
    parameter int TAG_W = $clog2(DEPTH)
);
    logic             alloc_en;
    logic [BH_W-1:0]  alloc_bh;
    logic             alloc_ready;
    logic [TAG_W-1:0] alloc_tag;
    logic             retire_en;
    logic [TAG_W-1:0] retire_tag;
    logic             squash_en;
    logic [TAG_W-1:0] squash_tag;
    logic             pred_valid;
    logic [BH_W-1:0]  pred_bh;
    logic [TAG_W:0]   count;
    logic             full;
    logic             empty;

    modport master (
        output alloc_en, alloc_bh, retire_en, retire_tag, squash_en, squash_tag,
        input  alloc_ready, alloc_tag, pred_valid, pred_bh, count, full, empty
    );

    modport slave (
        input  alloc_en, alloc_bh, retire_en, retire_tag, squash_en, squash_tag,
        output alloc_ready, alloc_tag, pred_valid, pred_bh, count, full, empty
    );
endinterface

// File: rtl/obq_ring.sv
// rtl/obq_ring.sv - circular ordered branch-history queue with head/tail ring pointers
module obq_ring #(
    parameter int DEPTH          = 8,
    parameter int BH_W           = 8,
    parameter int FLIP_ON_SQUASH = 1,
    parameter int TAG_W          = $clog2(DEPTH)
) (
    input  logic      clock,
    input  logic      reset,
    obq_ring_if.slave bus
);
    localparam int CW = TAG_W + 1;

    logic [BH_W-1:0]  entries [DEPTH];
    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] tail;
    logic [CW-1:0]    count;

    logic [TAG_W-1:0] sq_dist;
    logic [TAG_W-1:0] rt_dist;
    logic             sq_live;
    logic             rt_live;
    logic             alloc_ok;
    logic             is_full;
    logic             is_empty;

    logic [TAG_W-1:0] tail_sq;
    logic [CW-1:0]    count_sq;
    logic [TAG_W-1:0] head_n;
    logic [CW-1:0]    count_rt;
    logic [TAG_W-1:0] tail_n;
    logic [CW-1:0]    count_n;

    // Liveness is the modular distance from head, so it holds across pointer wrap.
    assign sq_dist  = bus.squash_tag - head;
    assign rt_dist  = bus.retire_tag - head;
    assign sq_live  = bus.squash_en && ({1'b0, sq_dist} < count);
    assign rt_live  = bus.retire_en && ({1'b0, rt_dist} < count);

    assign is_full  = (count == CW'(DEPTH));
    assign is_empty = (count == '0);
    assign alloc_ok = bus.alloc_en && !is_full;

    always_comb begin
        tail_sq  = tail;
        count_sq = count;
        if (sq_live) begin
            tail_sq  = bus.squash_tag + TAG_W'(1);
            count_sq = {1'b0, sq_dist} + CW'(1);
        end
    end

    // A retire at or beyond the squash point drains everything the squash left behind.
    always_comb begin
        head_n   = head;
        count_rt = count_sq;
        if (rt_live) begin
            if (sq_live && (rt_dist >= sq_dist)) begin
                head_n   = tail_sq;
                count_rt = '0;
            end else begin
                head_n   = bus.retire_tag + TAG_W'(1);
                count_rt = count_sq - ({1'b0, rt_dist} + CW'(1));
            end
        end
    end

    always_comb begin
        tail_n  = tail_sq;
        count_n = count_rt;
        if (alloc_ok) begin
            tail_n  = tail_sq + TAG_W'(1);
            count_n = count_rt + CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            head  <= head_n;
            tail  <= tail_n;
            count <= count_n;
            if (sq_live && (FLIP_ON_SQUASH != 0)) begin
                entries[bus.squash_tag][BH_W-1] <= ~entries[bus.squash_tag][BH_W-1];
            end
            if (alloc_ok) begin
                entries[tail_sq] <= bus.alloc_bh;
            end
        end
    end

    assign bus.alloc_ready = !is_full;
    assign bus.alloc_tag   = tail_sq;
    assign bus.full        = is_full;
    assign bus.empty       = is_empty;
    assign bus.count       = count;
    assign bus.pred_valid  = !is_empty;
    assign bus.pred_bh     = is_empty ? '0 : entries[tail - TAG_W'(1)];
endmodule

// File: doc/obq_ring.md
Name: obq_ring

Overview:
- Parametrised circular ordered branch-history queue; successor to the shift-based OBQ.
- Holds one branch-history row per in-flight branch, oldest at head, youngest at tail-1.
- Replaces entry shifting with head/tail ring pointers and supports any power-of-two depth and history width.
- Sits between fetch (allocate and predict), execute (squash on mispredict) and retire (commit oldest branches).

Parameters:
DEPTH, 8, number of entries; power of two, >= 2
BH_W, 8, branch-history bits per entry
FLIP_ON_SQUASH, 1, 1 = invert bit BH_W-1 of the squashing entry; 0 = leave the entry unchanged
TAG_W, $clog2(DEPTH), width of entry tags (physical slot index)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
alloc_en  in  1  allocate a new entry this cycle
alloc_bh  in  BH_W  history row to write
alloc_ready  out  1  ~full; an allocation is accepted only when alloc_en & alloc_ready
alloc_tag  out  TAG_W  slot the allocation in this cycle occupies (combinational)
retire_en  in  1  commit entries from head through retire_tag inclusive
retire_tag  in  TAG_W  youngest entry being committed
squash_en  in  1  mispredict; discard all entries younger than squash_tag
squash_tag  in  TAG_W  mispredicted branch's entry
pred_valid  out  1  queue non-empty
pred_bh  out  BH_W  row at tail-1 (youngest); 0 when empty
count  out  TAG_W+1  occupied entries
full  out  1  count == DEPTH
empty  out  1  count == 0

Behaviour:
- State: entries[DEPTH], head and tail of TAG_W bits, count of TAG_W+1 bits. Pointers wrap modulo DEPTH with no special case.
- Reset: entries=0, head=0, tail=0, count=0. Outputs after reset: pred_valid=0, pred_bh=0, full=0, empty=1, alloc_ready=1, alloc_tag=0.
- All outputs are combinational from registered state except alloc_tag, which also depends on squash_en/squash_tag.
- Tag validity: a tag t is live iff (t - head) mod DEPTH < count. A retire or squash with a non-live tag is ignored entirely with no side effects.
- Squash (live tag s):
  - tail_next = s+1.
  - count reduced to ((s-head) mod DEPTH)+1.
  - If FLIP_ON_SQUASH, entries[s][BH_W-1] is inverted. Entry s itself is kept; the corrected history persists.
- Retire (live tag r): head_next = r+1; count reduced by ((r-head) mod DEPTH)+1.
- Allocate (accepted):
  - entries[alloc_tag] = alloc_bh; tail advances by 1; count increases by 1.
  - alloc_tag = live squash ? s+1 : tail.
- Simultaneous events, applied in this order within one cycle: squash, then retire, then allocate.
  - squash+alloc: the new entry lands at s+1. The flipped entry s becomes pred_bh on the next cycle only if no alloc occurs.
  - retire+squash, same tag: the bit flip is applied and then the entry is committed; the queue ends empty unless an alloc occurs.
  - retire tag younger than squash tag: retire is evaluated against pre-squash liveness and clipped so head_next <= tail_next. Equivalently, the queue ends empty plus any alloc.
- Full: alloc_ready=0 when full, even if a retire or squash frees space in the same cycle. There is no combinational ready path. alloc_en while full is dropped, with no state change.
- Empty: retire and squash are ignored (no tag is live); alloc proceeds normally.
- Latency: updates are visible one cycle after the request edge. pred_bh reflects a new allocation on the next cycle.
- Wrap-around: tags remain physical slots across wrap. Liveness uses modular distance from head, never a raw compare.
- Reset mid-operation: all pending requests in that cycle are discarded and the state returns to reset values.
- Invariants (bench assertions): count == (tail-head) mod DEPTH, except count == DEPTH when full; count <= DEPTH; empty and full are never both 1.

Test Plan:
- Reset, then 3 allocs of 0x11, 0x22, 0x33 -> alloc_tags 0, 1, 2; count=3; pred_bh=0x33; head=0, tail=3.
- Fill to 8 entries, then alloc 0x99 -> full=1, alloc_ready=0, the 0x99 write is dropped, count stays 8. Then retire_tag=1 -> count=6, head=2; the next alloc gets tag 0 (wrap).
- Entries at tags 0-4 with [0]=0x0F, squash_tag=2 where entry 2=0x05 -> count=3, tail=3, pred_bh=0x85 (FLIP_ON_SQUASH=1); with FLIP_ON_SQUASH=0, pred_bh=0x05.
- Same cycle: squash_tag=2, alloc 0xAA, retire_tag=0, queue holds tags 0-4 -> head=1, tail=4, entry 3=0xAA, count=3, entry 2 bit 7 flipped.
- Head=6, tail=2, count=4 (wrapped); squash_tag=3 (non-live) and retire_tag=5 (non-live) -> no change. Then squash_tag=7 -> count=2, tail=0.
- Reset asserted while alloc_en and squash_en are high -> next cycle count=0, empty=1, pred_bh=0.
